serial_bcd_alu_p: RTL and testbench
===================================

Name: serial_bcd_alu_p

Overview:
- Parametrised successor to the team's fixed-width serial BCD ALU.
- Accepts a bit-serial frame (2-bit opcode, then BCD operand A, then BCD operand B, all LSB-first) while en is high.
- Computes add, subtract (sign-magnitude), max or min digit-serially, then shifts the (DIGITS+1)-digit BCD result out LSB-first with a valid strobe.
- Sits between the serial front-end and the result deserialiser.

Parameters:
- DIGITS, 4: BCD digits per operand (legal range 1..16). Result is DIGITS+1 digits.
- FRAME_BITS, 2+8*DIGITS: derived, never overridden. Input frame length in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  frame-enable; high for exactly FRAME_BITS consecutive cycles per frame.
- in  in  1  serial data, sampled on clk rising edge when en=1.
- result  out  1  serial result bit, LSB-first; 0 when result_valid=0.
- result_valid  out  1  high for exactly 4*(DIGITS+1) consecutive cycles per completed frame.
- busy  out  1  high in LOAD, CMP, CALC and OUT.
- err  out  1  invalid-BCD flag; high throughout the OUT window of a frame containing a nibble >9.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; result=0, result_valid=0, busy=0, err=0; bit counter and operand registers cleared. Reset overrides every state, including mid-OUT.
- Frame format, in arrival order:
  - op[0], op[1].
  - A: 4*DIGITS bits, LSB of the least-significant digit first.
  - B: same ordering as A.
- Opcodes: 00 = A+B; 01 = |A-B|; 10 = max(A,B); 11 = min(A,B).
- IDLE: an edge with en=1 captures in as frame bit 0; go to LOAD with count=1.
- LOAD: each edge with en=1 shifts in one bit.
  - When bit FRAME_BITS-1 is captured (edge E0), go to CMP.
  - en=0 at any LOAD edge aborts: discard the frame, go to IDLE, no outputs, err unchanged.
- CMP: DIGITS cycles, scanning from the most-significant digit.
  - Determines A>B, A==B or A<B.
  - Sets an internal error flag if any A or B nibble is >9.
  - At edge E0+DIGITS go to CALC.
- CALC: DIGITS cycles, one digit per cycle from the least-significant digit, using a carry/borrow flop and BCD correction (+6 on add when the digit sum >9; +10 on borrow for subtract). Per opcode:
  - Add: top result digit = final carry (0 or 1).
  - Sub: if A<B, the operands are swapped and the top digit = 4'hD (negative marker); otherwise the top digit = 0. A==B gives all zeros.
  - Max/min: the operand selected by the CMP result is copied digit by digit; top digit = 0.
  - At edge E0+2*DIGITS go to OUT.
- OUT:
  - From edge E0+2*DIGITS, result_valid=1 and result = result bit 0.
  - One bit per cycle for 4*(DIGITS+1) cycles.
  - At the following edge go to IDLE; result_valid=0, result=0.
- Error handling: if the error flag is set, the result register is forced to all zeros and err=1 for the whole OUT window. err is cleared when the next frame's bit 0 is captured.
- Latency: first result bit is valid 2*DIGITS cycles after the last input bit is sampled. This latency is fixed for every opcode.
- en=1 during CMP/CALC/OUT is ignored (bits are dropped, no abort). A new frame is accepted only at an edge where state=IDLE, i.e. no earlier than the edge after result_valid falls.
- busy=1 from the edge capturing bit 0 until the edge that returns to IDLE.

Test Plan (DIGITS=4, so 34-bit frames; results written as 5-digit hex/BCD):
- Add: op=00, A=1234, B=5678 -> result 20'h06912; result_valid exactly 20 cycles; first bit 8 cycles after the last input bit; err=0.
- Add carry: A=9999, B=9999 -> 20'h19998.
- Sub negative: op=01, A=0100, B=0250 -> 20'hD0150. Sub equal: A=B=4321 -> 20'h00000.
- Max/min: A=0999, B=1000. op=10 -> 20'h01000; op=11 -> 20'h00999.
- Invalid BCD: op=00, A=12A4, B=0001 -> err=1 for all 20 valid cycles, result all 0. The next valid frame clears err.
- Abort and reset:
  - en drops after 10 bits -> busy falls next cycle, no result_valid. An immediately following full frame (A=0001+B=0001) -> 20'h00002.
  - rst_n=0 mid-OUT -> result_valid=0 and result=0 at that edge, state=IDLE.

Source files
------------

// File: rtl/serial_bcd_alu_p.sv
// Bit-serial BCD ALU: loads an opcode plus two DIGITS-digit operands LSB-first,
// then computes add / |sub| / max / min one digit per cycle and streams the result out.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for en; the first en edge captures frame bit 0
// LOAD   | shifting in the remaining frame bits; en low aborts
// CMP    | MSD-first magnitude compare and invalid-nibble scan
// CALC   | LSD-first digit arithmetic with carry/borrow flop
// OUT    | result shifted out LSB-first with result_valid high
module serial_bcd_alu_p #(
  parameter int DIGITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic in,
  output logic result,
  output logic result_valid,
  output logic busy,
  output logic err
);

  localparam int FRAME_BITS = 2 + 8 * DIGITS;
  localparam int OUT_BITS   = 4 * (DIGITS + 1);
  localparam int CW         = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CMP, S_CALC, S_OUT} state_t;

  state_t                  state, state_d;
  logic [CW-1:0]           cnt;
  logic [FRAME_BITS-1:0]   frame_sr;
  logic [4*DIGITS-1:0]     res;
  logic [OUT_BITS-1:0]     out_sr;
  logic                    gt, lt, bad, cy;

  logic                    last;
  int                      idx;
  logic [3:0]              a_dig, b_dig, x, y, dig, top;
  logic [4:0]              sum, diff;
  logic                    cy_d;
  logic [4*DIGITS-1:0]     res_next;
  logic [1:0]              op;

  assign last   = (cnt == '0);
  assign op     = frame_sr[1:0];
  assign busy   = (state != S_IDLE);
  assign result = result_valid & out_sr[0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (en) state_d = S_LOAD;
      S_LOAD: begin
        if (!en)       state_d = S_IDLE;
        else if (last) state_d = S_CMP;
      end
      S_CMP:  if (last) state_d = S_CALC;
      S_CALC: if (last) state_d = S_OUT;
      S_OUT:  if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // CMP walks digits MSD-first (cnt counts down), CALC walks them LSD-first.
  always_comb begin
    idx = (state == S_CALC) ? (DIGITS - 1 - int'(cnt)) : int'(cnt);
    if (idx < 0 || idx >= DIGITS) idx = 0;
    a_dig = frame_sr[2 + 4*idx +: 4];
    b_dig = frame_sr[2 + 4*DIGITS + 4*idx +: 4];
    x     = a_dig;
    y     = b_dig;
    case (op)
      2'b01: if (lt) begin x = b_dig; y = a_dig; end
      2'b10: if (lt) x = b_dig;
      2'b11: if (!lt) x = b_dig;
      default: ;
    endcase
    sum  = {1'b0, x} + {1'b0, y} + {4'b0, cy};
    diff = {1'b0, x} - {1'b0, y} - {4'b0, cy};
    dig  = x;
    cy_d = 1'b0;
    top  = 4'h0;
    case (op)
      2'b00: begin
        if (sum > 5'd9) begin
          dig  = sum[3:0] + 4'd6;
          cy_d = 1'b1;
        end else begin
          dig  = sum[3:0];
        end
        top = {3'b0, cy_d};
      end
      2'b01: begin
        if (diff[4]) begin
          dig  = diff[3:0] + 4'd10;
          cy_d = 1'b1;
        end else begin
          dig  = diff[3:0];
        end
        top = lt ? 4'hD : 4'h0;
      end
      default: ;
    endcase
    res_next = res >> 4;
    res_next[4*DIGITS-4 +: 4] = dig;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      frame_sr     <= '0;
      res          <= '0;
      out_sr       <= '0;
      gt           <= 1'b0;
      lt           <= 1'b0;
      bad          <= 1'b0;
      cy           <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            frame_sr <= {in, frame_sr[FRAME_BITS-1:1]};
            cnt      <= CW'(FRAME_BITS - 2);
            err      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (en) begin
            frame_sr <= {in, frame_sr[FRAME_BITS-1:1]};
            if (last) begin
              cnt <= CW'(DIGITS - 1);
              gt  <= 1'b0;
              lt  <= 1'b0;
              bad <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        S_CMP: begin
          if (!gt && !lt) begin
            if (a_dig > b_dig)      gt <= 1'b1;
            else if (a_dig < b_dig) lt <= 1'b1;
          end
          if (a_dig > 4'd9 || b_dig > 4'd9) bad <= 1'b1;
          if (last) begin
            cnt <= CW'(DIGITS - 1);
            cy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_CALC: begin
          res <= res_next;
          cy  <= cy_d;
          if (last) begin
            out_sr       <= bad ? '0 : {top, res_next};
            result_valid <= 1'b1;
            err          <= bad;
            cnt          <= CW'(OUT_BITS - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_OUT: begin
          out_sr <= out_sr >> 1;
          if (last) result_valid <= 1'b0;
          else      cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bcd_alu_p.sv
// Scoreboard bench for serial_bcd_alu_p (DIGITS=4): frames pushed on drive,
// results popped and compared as the DUT streams them out.
module tb_serial_bcd_alu_p;

  localparam int DIGITS = 4;
  localparam int FB     = 2 + 8 * DIGITS;
  localparam int OB     = 4 * (DIGITS + 1);

  logic clk = 1'b0;
  logic rst_n, en, in;
  logic result, result_valid, busy, err;

  int errors = 0;
  int checks = 0;

  logic [OB-1:0] exp_q[$];
  logic          exp_err_q[$];

  always #5 clk = ~clk;

  serial_bcd_alu_p #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in),
    .result(result), .result_valid(result_valid), .busy(busy), .err(err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit bcd_ok(input logic [15:0] v);
    for (int d = 0; d < DIGITS; d++)
      if (v[4*d +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int d = DIGITS - 1; d >= 0; d--) r = r * 10 + int'(v[4*d +: 4]);
    return r;
  endfunction

  function automatic logic [OB-1:0] int2bcd(input int v);
    logic [OB-1:0] r = '0;
    int t = v;
    for (int d = 0; d < DIGITS + 1; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic send_frame(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                            input bit push);
    logic [FB-1:0] f;
    logic [OB-1:0] e, mag;
    bit            ee;
    int            ai, bi;
    f  = {b, a, op};
    ai = bcd2int(a);
    bi = bcd2int(b);
    ee = !(bcd_ok(a) && bcd_ok(b));
    e  = '0;
    if (!ee) begin
      case (op)
        2'b00: e = int2bcd(ai + bi);
        2'b01: begin
          if (ai < bi) begin
            mag = int2bcd(bi - ai);
            e   = {4'hD, mag[OB-5:0]};
          end else begin
            e = int2bcd(ai - bi);
          end
        end
        2'b10: e = int2bcd((ai > bi) ? ai : bi);
        default: e = int2bcd((ai < bi) ? ai : bi);
      endcase
    end
    if (push) begin
      exp_q.push_back(e);
      exp_err_q.push_back(ee);
    end
    for (int i = 0; i < FB; i++) begin
      en = 1'b1;
      in = f[i];
      @(negedge clk);
    end
    en = 1'b0;
    in = 1'b0;
  endtask

  // Called right after the negedge following the last input bit.
  task automatic collect(input string name);
    int            lat = 0;
    int            vcnt = 0;
    int            err_bad = 0;
    logic [OB-1:0] got = '0;
    logic [OB-1:0] e = '0;
    logic          ee = 1'b0;
    while (!result_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_val({name, "_latency"}, lat, 8);
    check_val({name, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      ee = exp_err_q.pop_front();
    end
    for (int i = 0; i < OB; i++) begin
      got[i] = result;
      if (result_valid) vcnt++;
      if (err !== ee) err_bad++;
      @(negedge clk);
    end
    check_val({name, "_result"}, 32'(got), 32'(e));
    check_val({name, "_valid_len"}, vcnt, OB);
    check_val({name, "_err_mismatch_cycles"}, err_bad, 0);
    check_val({name, "_valid_after"}, 32'(result_valid), 0);
    check_val({name, "_busy_after"}, 32'(busy), 0);
  endtask

  initial begin
    int wait_cnt;
    rst_n = 1'b0;
    en    = 1'b0;
    in    = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_valid", 32'(result_valid), 0);
    check_val("rst_result", 32'(result), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(2'b00, 16'h1234, 16'h5678, 1); collect("add");
    send_frame(2'b00, 16'h9999, 16'h9999, 1); collect("add_carry");
    send_frame(2'b01, 16'h0100, 16'h0250, 1); collect("sub_neg");
    send_frame(2'b01, 16'h4321, 16'h4321, 1); collect("sub_eq");
    send_frame(2'b01, 16'h5000, 16'h1234, 1); collect("sub_pos");
    send_frame(2'b10, 16'h0999, 16'h1000, 1); collect("max");
    send_frame(2'b11, 16'h0999, 16'h1000, 1); collect("min");
    send_frame(2'b00, 16'h12A4, 16'h0001, 1); collect("bad_bcd");
    send_frame(2'b10, 16'h0042, 16'h0017, 1); collect("err_cleared");

    // Abort after 10 bits.
    for (int i = 0; i < 10; i++) begin
      en = 1'b1;
      in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    en = 1'b0;
    in = 1'b0;
    @(negedge clk);
    check_val("abort_busy", 32'(busy), 0);
    check_val("abort_valid", 32'(result_valid), 0);
    send_frame(2'b00, 16'h0001, 16'h0001, 1); collect("after_abort");

    // Reset in the middle of the output window.
    send_frame(2'b00, 16'h1234, 16'h5678, 0);
    wait_cnt = 0;
    while (!result_valid && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    check_val("midout_reached", 32'(result_valid), 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("midout_rst_valid", 32'(result_valid), 0);
    check_val("midout_rst_result", 32'(result), 0);
    check_val("midout_rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(2'b11, 16'h5555, 16'h5554, 1); collect("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
